// File: rtl/cmd_frame_parser.sv
// cmd_frame_parser: USB CDC byte-stream framer.
// Buffers and checksum-verifies frames, then replays verified payloads.
module cmd_frame_parser #(
  parameter int MAX_PAYLOAD    = 64,
  parameter int TIMEOUT_CYCLES = 60000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  usb_data_in,
  input  logic        usb_data_valid_in,
  output logic        cmd_valid,
  output logic [7:0]  cmd_type,
  output logic [15:0] cmd_length,
  output logic [7:0]  cmd_data,
  output logic        cmd_data_valid,
  output logic [15:0] cmd_data_index,
  output logic        cmd_done,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [7:0]  drop_cnt
);

  localparam int IW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR2, S_CMD, S_LENH,
    S_LENL, S_PAY, S_CHK, S_EMIT
  } state_t;

  state_t r_state, w_next;

  logic [7:0]    r_buf [MAX_PAYLOAD];
  logic [7:0]    r_sh_type;
  logic [15:0]   r_sh_len;
  logic [7:0]    r_sum;
  logic [15:0]   r_wr_idx;
  logic [15:0]   r_rd_idx;
  logic [TW-1:0] r_tmo;

  logic          w_byte;
  logic          w_in_frame;
  logic          w_tmo_exp;
  logic          w_err;
  logic [1:0]    w_code;
  logic          w_ok;
  logic [15:0]   w_len;

  assign w_byte     = usb_data_valid_in;
  assign w_len      = {r_sh_len[15:8], usb_data_in};
  assign w_in_frame = (r_state != S_IDLE) && (r_state != S_EMIT);
  assign w_tmo_exp  = w_in_frame && !w_byte &&
                      (r_tmo == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    w_code = 2'd0;
    w_ok   = 1'b0;
    unique case (r_state)
      S_IDLE:
        if (w_byte && usb_data_in == 8'hAA) w_next = S_HDR2;
      S_HDR2:
        if (w_byte) begin
          if (usb_data_in == 8'h55)      w_next = S_CMD;
          else if (usb_data_in != 8'hAA) w_next = S_IDLE;
        end
      S_CMD:
        if (w_byte) w_next = S_LENH;
      S_LENH:
        if (w_byte) w_next = S_LENL;
      S_LENL:
        if (w_byte) begin
          if (w_len > 16'(MAX_PAYLOAD)) begin
            w_next = S_IDLE;
            w_err  = 1'b1;
            w_code = 2'd2;
          end else if (w_len == 16'd0) begin
            w_next = S_CHK;
          end else begin
            w_next = S_PAY;
          end
        end
      S_PAY:
        if (w_byte && r_wr_idx == r_sh_len - 16'd1) w_next = S_CHK;
      S_CHK:
        if (w_byte) begin
          if (usb_data_in == r_sum) begin
            w_next = S_EMIT;
            w_ok   = 1'b1;
          end else begin
            w_next = S_IDLE;
            w_err  = 1'b1;
            w_code = 2'd1;
          end
        end
      S_EMIT:
        if (cmd_done) w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
    if (w_tmo_exp) begin
      w_next = S_IDLE;
      w_err  = 1'b1;
      w_code = 2'd3;
    end
  end

  // Payload store has no reset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (r_state == S_PAY && w_byte)
      r_buf[r_wr_idx[IW-1:0]] <= usb_data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_type      <= '0;
      r_sh_len       <= '0;
      r_sum          <= '0;
      r_wr_idx       <= '0;
      r_rd_idx       <= '0;
      r_tmo          <= '0;
      cmd_valid      <= 1'b0;
      cmd_type       <= '0;
      cmd_length     <= '0;
      cmd_data       <= '0;
      cmd_data_valid <= 1'b0;
      cmd_data_index <= '0;
      cmd_done       <= 1'b0;
      frame_err      <= 1'b0;
      err_code       <= '0;
      drop_cnt       <= '0;
    end else begin
      cmd_valid      <= 1'b0;
      cmd_data_valid <= 1'b0;
      cmd_done       <= 1'b0;
      frame_err      <= w_err;
      if (w_err) err_code <= w_code;

      if (!w_in_frame || w_byte || w_tmo_exp) r_tmo <= '0;
      else                                    r_tmo <= r_tmo + 1'b1;

      if (w_byte) begin
        if (r_state == S_CMD) begin
          r_sh_type <= usb_data_in;
          r_sum     <= usb_data_in;
        end
        if (r_state == S_LENH) begin
          r_sh_len[15:8] <= usb_data_in;
          r_sum          <= r_sum + usb_data_in;
        end
        if (r_state == S_LENL) begin
          r_sh_len[7:0] <= usb_data_in;
          r_sum         <= r_sum + usb_data_in;
          r_wr_idx      <= '0;
        end
        if (r_state == S_PAY) begin
          r_sum    <= r_sum + usb_data_in;
          r_wr_idx <= r_wr_idx + 16'd1;
        end
        if (r_state == S_EMIT && drop_cnt != 8'hFF)
          drop_cnt <= drop_cnt + 8'd1;
      end

      if (w_ok) begin
        cmd_valid  <= 1'b1;
        cmd_type   <= r_sh_type;
        cmd_length <= r_sh_len;
        r_rd_idx   <= '0;
      end

      // Done cycle stays in EMIT so a byte arriving with cmd_done is dropped.
      if (r_state == S_EMIT && !cmd_done) begin
        if (r_rd_idx < cmd_length) begin
          cmd_data       <= r_buf[r_rd_idx[IW-1:0]];
          cmd_data_valid <= 1'b1;
          cmd_data_index <= r_rd_idx;
          r_rd_idx       <= r_rd_idx + 16'd1;
        end else begin
          cmd_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmd_frame_parser.sv
// tb_cmd_frame_parser: directed and random frames checked against
// expected command/error events derived from the frame rules.
module tb_cmd_frame_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  din = '0;
  logic        dv = 1'b0;
  logic        cmd_valid;
  logic [7:0]  cmd_type;
  logic [15:0] cmd_length;
  logic [7:0]  cmd_data;
  logic        cmd_data_valid;
  logic [15:0] cmd_data_index;
  logic        cmd_done;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [7:0]  drop_cnt;

  cmd_frame_parser #(.MAX_PAYLOAD(64), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n),
    .usb_data_in(din), .usb_data_valid_in(dv),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type),
    .cmd_length(cmd_length), .cmd_data(cmd_data),
    .cmd_data_valid(cmd_data_valid),
    .cmd_data_index(cmd_data_index),
    .cmd_done(cmd_done), .frame_err(frame_err),
    .err_code(err_code), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail = 0;
  int last_acc = 0;

  int hq_t[$], hq_l[$], hq_c[$];
  int dq_d[$], dq_i[$], dq_c[$];
  int doneq[$];
  int eq_code[$], eq_c[$];
  logic [7:0] pl_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid) begin
        hq_t.push_back(int'(cmd_type));
        hq_l.push_back(int'(cmd_length));
        hq_c.push_back(cyc);
      end
      if (cmd_data_valid) begin
        dq_d.push_back(int'(cmd_data));
        dq_i.push_back(int'(cmd_data_index));
        dq_c.push_back(cyc);
      end
      if (cmd_done) doneq.push_back(cyc);
      if (frame_err) begin
        eq_code.push_back(int'(err_code));
        eq_c.push_back(cyc);
      end
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    hq_t.delete(); hq_l.delete(); hq_c.delete();
    dq_d.delete(); dq_i.delete(); dq_c.delete();
    doneq.delete(); eq_code.delete(); eq_c.delete();
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    dv = 1'b1;
    din = b;
    last_acc = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      dv = 1'b0;
    end
  endtask

  task automatic sendg(input logic [7:0] b, input int maxgap);
    idle($urandom_range(0, maxgap));
    send(b);
  endtask

  // Sends a frame carrying pl_q; chk_off != 0 corrupts the checksum.
  task automatic send_frame(input logic [7:0] cmd, input int chk_off,
                            input int maxgap);
    logic [15:0] l16;
    logic [7:0] s;
    l16 = 16'(pl_q.size());
    s = cmd + l16[15:8] + l16[7:0];
    sendg(8'hAA, maxgap);
    sendg(8'h55, maxgap);
    sendg(cmd, maxgap);
    sendg(l16[15:8], maxgap);
    sendg(l16[7:0], maxgap);
    foreach (pl_q[k]) begin
      s = s + pl_q[k];
      sendg(pl_q[k], maxgap);
    end
    sendg(s + 8'(chk_off), maxgap);
  endtask

  task automatic expect_good(input logic [7:0] cmd, input int c);
    int len;
    int nd;
    len = pl_q.size();
    idle(len + 4);
    chk("hdr_count", hq_t.size(), 1);
    if (hq_t.size() > 0) begin
      chk("cmd_type", hq_t[0], cmd);
      chk("cmd_length", hq_l[0], len);
      chk("cmd_valid_cycle", hq_c[0], c);
    end
    chk("data_count", dq_d.size(), len);
    nd = (dq_d.size() < len) ? dq_d.size() : len;
    for (int k = 0; k < nd; k++) begin
      chk("cmd_data", dq_d[k], pl_q[k]);
      chk("cmd_data_index", dq_i[k], k);
      chk("data_cycle", dq_c[k], c + 1 + k);
    end
    chk("done_count", doneq.size(), 1);
    if (doneq.size() > 0) chk("cmd_done_cycle", doneq[0], c + 1 + len);
    chk("err_count_good", eq_c.size(), 0);
    clear_q();
  endtask

  task automatic expect_err(input int code, input int c);
    idle(3);
    chk("err_count", eq_c.size(), 1);
    if (eq_c.size() > 0) begin
      chk("err_code_pulse", eq_code[0], code);
      chk("frame_err_cycle", eq_c[0], c);
    end
    chk("err_code_held", err_code, code);
    chk("hdr_count_err", hq_t.size(), 0);
    chk("data_count_err", dq_d.size(), 0);
    chk("done_count_err", doneq.size(), 0);
    clear_q();
  endtask

  function automatic longint outs();
    return longint'({cmd_valid, cmd_type, cmd_length, cmd_data,
                     cmd_data_valid, cmd_data_index, cmd_done,
                     frame_err, err_code, drop_cnt});
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int kind;
    int n;
    logic [7:0] cmd;
    logic [15:0] l16;
    logic [7:0] b;

    idle(3);
    chk("reset_outputs", outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    pl_q = '{8'h10, 8'h20};
    send_frame(8'h01, 0, 0);
    expect_good(8'h01, last_acc);

    send_frame(8'h01, 1, 0);
    expect_err(1, last_acc);
    send_frame(8'h01, 0, 0);
    expect_good(8'h01, last_acc);

    send(8'hAA); send(8'h55); send(8'h05); send(8'h00); send(8'h41);
    expect_err(2, last_acc);
    pl_q = '{8'h3C};
    send_frame(8'h02, 0, 1);
    expect_good(8'h02, last_acc);

    send(8'hAA); send(8'h55); send(8'h01); send(8'h00);
    send(8'h04); send(8'h11); send(8'h22);
    @(negedge clk);
    dv = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_frame_reset_outputs", outs(), 0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    clear_q();
    pl_q = '{8'hDE, 8'hAD, 8'hBE};
    send_frame(8'h09, 0, 0);
    expect_good(8'h09, last_acc);

    pl_q.delete();
    for (int k = 0; k < 64; k++) pl_q.push_back(8'($urandom));
    send_frame(8'h40, 0, 0);
    c = last_acc;
    idle(5);
    send(8'hAA);
    expect_good(8'h40, c);
    chk("drop_cnt_emit", drop_cnt, 1);

    pl_q.delete();
    send(8'h13); send(8'hAA); send(8'hAA); send(8'h55);
    send(8'h07); send(8'h00); send(8'h00); send(8'h07);
    c = last_acc;
    idle(1);
    send(8'hAA);
    expect_good(8'h07, c);
    chk("drop_cnt_done_cycle", drop_cnt, 2);

    send(8'hAA); send(8'h55); send(8'h01); send(8'h00);
    c = last_acc;
    idle(110);
    expect_err(3, c + 101);

    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 2);
      cmd = 8'($urandom);
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        if (b == 8'hAA) b = 8'h00;
        send(b);
      end
      pl_q.delete();
      n = $urandom_range(0, 64);
      for (int j = 0; j < n; j++) pl_q.push_back(8'($urandom));
      if (kind == 0) begin
        send_frame(cmd, 0, 3);
        expect_good(cmd, last_acc);
      end else if (kind == 1) begin
        send_frame(cmd, $urandom_range(1, 255), 3);
        expect_err(1, last_acc);
      end else begin
        l16 = 16'($urandom_range(65, 65535));
        sendg(8'hAA, 3); sendg(8'h55, 3); sendg(cmd, 3);
        sendg(l16[15:8], 3); sendg(l16[7:0], 3);
        expect_err(2, last_acc);
      end
    end
    chk("drop_cnt_final", drop_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
